// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared note width and allocator FSM state encoding
package voice_allocator_pkg;
    localparam int NOTE_W = 7;
    typedef enum logic [1:0] {IDLE, SCAN, APPLY, RETRIG} state_t;
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: MIDI note event handshake into the allocator
interface voice_allocator_if;
    import voice_allocator_pkg::*;
    logic              evt_valid;
    logic              evt_ready;
    logic              evt_note_on;
    logic [NOTE_W-1:0] evt_note;
    modport master(output evt_valid, evt_note_on, evt_note, input evt_ready);
    modport slave(input evt_valid, evt_note_on, evt_note, output evt_ready);
endinterface

// File: rtl/voice_age_tracker.sv
// voice_age_tracker: per-voice saturating ages and oldest-busy-voice query
module voice_age_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = 2
) (
    input  logic                  sample_clock,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  alloc,
    input  logic [IDX_W-1:0]      alloc_idx,
    input  logic [NUM_VOICES-1:0] gate,
    output logic [IDX_W-1:0]      oldest
);
    logic [IDX_W-1:0] age [NUM_VOICES];
    logic [IDX_W-1:0] best;
    logic             found;

    always_ff @(posedge sample_clock) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
        end else if (alloc) begin
            for (int i = 0; i < NUM_VOICES; i++)
                if (IDX_W'(i) == alloc_idx) age[i] <= '0;
                else if (gate[i] && age[i] != IDX_W'(NUM_VOICES - 1)) age[i] <= age[i] + 1'b1;
        end
    end

    // strict compare keeps the lowest index on equal ages
    always_comb begin
        oldest = '0;
        best   = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (gate[i] && (!found || age[i] > best)) begin
                found  = 1'b1;
                best   = age[i];
                oldest = IDX_W'(i);
            end
    end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note events to voices (reuse, free, or steal oldest)
module voice_allocator import voice_allocator_pkg::*; #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                         sample_clock,
    input  logic                         rst,
    voice_allocator_if.slave             evt,
    input  logic                         panic,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [IDX_W:0]               busy_count
);
    state_t            state;
    logic [IDX_W-1:0]  scan_idx, match_idx, free_idx, tgt_idx, oldest, tgt;
    logic              match_found, free_found, ev_on;
    logic [NOTE_W-1:0] ev_note;
    logic [NOTE_W-1:0] note_r [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_nxt;

    function automatic logic [IDX_W:0] popcount(input logic [NUM_VOICES-1:0] g);
        popcount = '0;
        for (int i = 0; i < NUM_VOICES; i++) popcount = popcount + (IDX_W+1)'(g[i]);
    endfunction

    assign evt.evt_ready = state == IDLE && !panic && !rst;
    assign tgt = match_found ? match_idx : free_found ? free_idx : oldest;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign voice_note[NOTE_W*v +: NOTE_W] = note_r[v];
    end

    voice_age_tracker #(.NUM_VOICES(NUM_VOICES), .IDX_W(IDX_W)) u_age (
        .sample_clock(sample_clock),
        .rst(rst),
        .clear(panic),
        .alloc(state == APPLY && ev_on),
        .alloc_idx(tgt),
        .gate(voice_gate),
        .oldest(oldest)
    );

    // retrigger and steal both drop the gate for one sample before RETRIG raises it
    always_comb begin
        gate_nxt = voice_gate;
        if (panic) gate_nxt = '0;
        else if (state == APPLY && ev_on) gate_nxt[tgt] = !match_found && free_found;
        else if (state == APPLY && match_found) gate_nxt[match_idx] = 1'b0;
        else if (state == RETRIG) gate_nxt[tgt_idx] = 1'b1;
    end

    always_ff @(posedge sample_clock) begin
        if (rst) begin
            state       <= IDLE;
            scan_idx    <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            tgt_idx     <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            ev_on       <= 1'b0;
            ev_note     <= '0;
            voice_gate  <= '0;
            busy_count  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) note_r[i] <= '0;
        end else begin
            voice_gate <= gate_nxt;
            busy_count <= popcount(gate_nxt);
            if (panic) state <= IDLE;
            else case (state)
                IDLE: if (evt.evt_valid) begin
                    state       <= SCAN;
                    scan_idx    <= '0;
                    match_found <= 1'b0;
                    free_found  <= 1'b0;
                    ev_on       <= evt.evt_note_on;
                    ev_note     <= evt.evt_note;
                end
                SCAN: begin
                    if (!match_found && voice_gate[scan_idx] && note_r[scan_idx] == ev_note) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!free_found && !voice_gate[scan_idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + 1'b1;
                    state    <= scan_idx == IDX_W'(NUM_VOICES - 1) ? APPLY : SCAN;
                end
                APPLY: begin
                    tgt_idx <= tgt;
                    if (ev_on) note_r[tgt] <= ev_note;
                    state <= ev_on && (match_found || !free_found) ? RETRIG : IDLE;
                end
                RETRIG: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed checks of allocation, stealing, retrigger, note-off, panic, reset
module tb_voice_allocator;
    logic        sample_clock = 1'b0;
    logic        rst = 1'b1;
    logic        panic = 1'b0;
    logic [27:0] voice_note;
    logic [3:0]  voice_gate;
    logic [2:0]  busy_count;
    int checks = 0;
    int passed = 0;

    voice_allocator_if bus();

    voice_allocator #(.NUM_VOICES(4), .IDX_W(2)) dut (
        .sample_clock(sample_clock),
        .rst(rst),
        .evt(bus),
        .panic(panic),
        .voice_note(voice_note),
        .voice_gate(voice_gate),
        .busy_count(busy_count)
    );

    always #5 sample_clock = ~sample_clock;

    task automatic step(input int n);
        repeat (n) @(posedge sample_clock);
        @(negedge sample_clock);
    endtask

    // returns just after the transfer edge
    task automatic send(input logic on, input logic [6:0] note);
        int n = 0;
        @(negedge sample_clock);
        while (!bus.evt_ready && n < 20) begin
            @(negedge sample_clock);
            n++;
        end
        checks++;
        if (bus.evt_ready !== 1'b1) $display("FAIL send_ready got=%b exp=1", bus.evt_ready);
        else passed++;
        bus.evt_valid   = 1'b1;
        bus.evt_note_on = on;
        bus.evt_note    = note;
        @(posedge sample_clock);
        #1 bus.evt_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if ({bus.evt_ready, voice_gate, voice_note, busy_count} !== 36'd0)
            $display("FAIL reset_state got ready=%b gate=%b note=%h count=%0d exp all 0", bus.evt_ready, voice_gate, voice_note, busy_count);
        else passed++;
        rst = 1'b0;
        step(1);
        checks++;
        if (bus.evt_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.evt_ready);
        else passed++;
    endtask

    task automatic test_note_on();
        send(1'b1, 7'd60);
        step(4);
        checks++;
        if ({voice_gate, bus.evt_ready} !== 5'b0000_0) $display("FAIL note_on_early got gate=%b ready=%b exp 0000/0", voice_gate, bus.evt_ready);
        else passed++;
        step(1);
        checks++;
        if ({voice_gate, voice_note[6:0], busy_count, bus.evt_ready} !== {4'b0001, 7'd60, 3'd1, 1'b1})
            $display("FAIL note_on got gate=%b note0=%0d count=%0d ready=%b exp 0001/60/1/1", voice_gate, voice_note[6:0], busy_count, bus.evt_ready);
        else passed++;
    endtask

    task automatic test_steal();
        send(1'b1, 7'd62); step(5);
        send(1'b1, 7'd64); step(5);
        send(1'b1, 7'd67); step(5);
        checks++;
        if ({voice_gate, voice_note, busy_count} !== {4'b1111, 7'd67, 7'd64, 7'd62, 7'd60, 3'd4})
            $display("FAIL fill got gate=%b note=%h count=%0d exp 1111/{67,64,62,60}/4", voice_gate, voice_note, busy_count);
        else passed++;
        send(1'b1, 7'd69);
        step(4);
        checks++;
        if (voice_gate !== 4'b1111) $display("FAIL steal_early got gate=%b exp=1111", voice_gate);
        else passed++;
        step(1);
        checks++;
        if ({voice_gate, voice_note, busy_count, bus.evt_ready} !== {4'b1110, 7'd67, 7'd64, 7'd62, 7'd69, 3'd3, 1'b0})
            $display("FAIL steal_low got gate=%b note=%h count=%0d ready=%b exp 1110/{67,64,62,69}/3/0", voice_gate, voice_note, busy_count, bus.evt_ready);
        else passed++;
        step(1);
        checks++;
        if ({voice_gate, busy_count, bus.evt_ready} !== {4'b1111, 3'd4, 1'b1})
            $display("FAIL steal_high got gate=%b count=%0d ready=%b exp 1111/4/1", voice_gate, busy_count, bus.evt_ready);
        else passed++;
    endtask

    task automatic test_retrigger();
        send(1'b1, 7'd67);
        step(5);
        checks++;
        if ({voice_gate, voice_note, busy_count} !== {4'b0111, 7'd67, 7'd64, 7'd62, 7'd69, 3'd3})
            $display("FAIL retrig_low got gate=%b note=%h count=%0d exp 0111/{67,64,62,69}/3", voice_gate, voice_note, busy_count);
        else passed++;
        step(1);
        checks++;
        if ({voice_gate, voice_note, busy_count, bus.evt_ready} !== {4'b1111, 7'd67, 7'd64, 7'd62, 7'd69, 3'd4, 1'b1})
            $display("FAIL retrig_high got gate=%b note=%h count=%0d ready=%b exp 1111/same/4/1", voice_gate, voice_note, busy_count, bus.evt_ready);
        else passed++;
    endtask

    task automatic test_note_off();
        send(1'b0, 7'd62);
        step(4);
        checks++;
        if (voice_gate !== 4'b1111) $display("FAIL off_early got gate=%b exp=1111", voice_gate);
        else passed++;
        step(1);
        checks++;
        if ({voice_gate, voice_note, busy_count, bus.evt_ready} !== {4'b1101, 7'd67, 7'd64, 7'd62, 7'd69, 3'd3, 1'b1})
            $display("FAIL off_held got gate=%b note=%h count=%0d ready=%b exp 1101/{67,64,62,69}/3/1", voice_gate, voice_note, busy_count, bus.evt_ready);
        else passed++;
        send(1'b0, 7'd50);
        step(5);
        checks++;
        if ({voice_gate, voice_note, busy_count} !== {4'b1101, 7'd67, 7'd64, 7'd62, 7'd69, 3'd3})
            $display("FAIL off_unheld got gate=%b note=%h count=%0d exp 1101/unchanged/3", voice_gate, voice_note, busy_count);
        else passed++;
        send(1'b1, 7'd50);
        step(5);
        checks++;
        if ({voice_gate, voice_note, busy_count} !== {4'b1111, 7'd67, 7'd64, 7'd50, 7'd69, 3'd4})
            $display("FAIL free_hole got gate=%b note=%h count=%0d exp 1111/{67,64,50,69}/4", voice_gate, voice_note, busy_count);
        else passed++;
    endtask

    task automatic test_panic();
        send(1'b1, 7'd64);
        @(posedge sample_clock);
        #1 panic = 1'b1;
        @(negedge sample_clock);
        checks++;
        if (bus.evt_ready !== 1'b0) $display("FAIL panic_ready got=%b exp=0", bus.evt_ready);
        else passed++;
        @(posedge sample_clock);
        #1 panic = 1'b0;
        @(negedge sample_clock);
        checks++;
        if ({voice_gate, voice_note, busy_count, bus.evt_ready} !== {4'b0000, 7'd67, 7'd64, 7'd50, 7'd69, 3'd0, 1'b1})
            $display("FAIL panic_clear got gate=%b note=%h count=%0d ready=%b exp 0000/{67,64,50,69}/0/1", voice_gate, voice_note, busy_count, bus.evt_ready);
        else passed++;
        step(6);
        checks++;
        if ({voice_gate, busy_count} !== 7'd0) $display("FAIL panic_dropped got gate=%b count=%0d exp 0000/0", voice_gate, busy_count);
        else passed++;
        panic = 1'b1;
        bus.evt_valid   = 1'b1;
        bus.evt_note_on = 1'b1;
        bus.evt_note    = 7'd40;
        #1;
        checks++;
        if (bus.evt_ready !== 1'b0) $display("FAIL panic_valid_ready got=%b exp=0", bus.evt_ready);
        else passed++;
        @(posedge sample_clock);
        #1 begin panic = 1'b0; bus.evt_valid = 1'b0; end
        step(6);
        checks++;
        if ({voice_gate, voice_note} !== {4'b0000, 7'd67, 7'd64, 7'd50, 7'd69})
            $display("FAIL panic_valid_drop got gate=%b note=%h exp 0000/{67,64,50,69}", voice_gate, voice_note);
        else passed++;
        send(1'b1, 7'd72);
        step(5);
        checks++;
        if ({voice_gate, voice_note, busy_count} !== {4'b0001, 7'd67, 7'd64, 7'd50, 7'd72, 3'd1})
            $display("FAIL after_panic got gate=%b note=%h count=%0d exp 0001/{67,64,50,72}/1", voice_gate, voice_note, busy_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        send(1'b1, 7'd74);
        @(posedge sample_clock);
        #1 rst = 1'b1;
        @(posedge sample_clock);
        #1 rst = 1'b0;
        @(negedge sample_clock);
        checks++;
        if ({voice_gate, voice_note, busy_count, bus.evt_ready} !== {32'd0, 3'd0, 1'b1})
            $display("FAIL reset_mid got gate=%b note=%h count=%0d ready=%b exp 0/0/0/1", voice_gate, voice_note, busy_count, bus.evt_ready);
        else passed++;
        step(6);
        checks++;
        if ({voice_gate, voice_note} !== 32'd0) $display("FAIL reset_mid_drop got gate=%b note=%h exp 0/0", voice_gate, voice_note);
        else passed++;
    endtask

    initial begin
        bus.evt_valid   = 1'b0;
        bus.evt_note_on = 1'b0;
        bus.evt_note    = '0;
        test_reset();
        test_note_on();
        test_steal();
        test_retrigger();
        test_note_off();
        test_panic();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
